muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide controller for the 54-instruction MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the HI/LO architectural registers. It drives an iterative radix-2 datapath one step per cycle and raises busy so the pipeline can stall MFHI/MFLO and later mul/div ops. It sits in EX, beside the ALU and the combinational low-word multiplier.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_iter_core.sv | 61 ++++++
 rtl/muldiv_ctrl.sv | 173 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and default width for the mul/div unit
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - 2*WIDTH accumulator with one radix-2 multiply/divide step per cycle
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : clear the accumulator (accept cycle)
//   step       : perform one iteration
//   is_div     : 1 = restoring divide step, 0 = shift-add multiply step
//   a_bit      : current operand-a magnitude bit, fed MSB first
//   op_b       : divisor / multiplicand magnitude
//   acc        : {HI half, LO half}; divide keeps remainder high, quotient low
import muldiv_pkg::*;

module muldiv_iter_core #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic               a_bit,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   new_rem;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        // Restoring divide: bring in the next dividend bit, subtract if it fits.
        partial = {acc_q[2*WIDTH-1:WIDTH], a_bit};
        diff    = partial - {1'b0, op_b};
        ge      = (partial >= {1'b0, op_b});
        // When the trial fails partial < op_b, so its top bit is zero.
        new_rem = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        // MSB-first shift-add multiply.
        mul_next = {acc_q[2*WIDTH-2:0], 1'b0} + (a_bit ? {{WIDTH{1'b0}}, op_b} : '0);
        acc_d = acc_q;
        if (load) begin
            acc_d = '0;
        end else if (step) begin
            acc_d = is_div ? {new_rem, acc_q[WIDTH-2:0], ge} : mul_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO controller owning HI/LO
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start, op  : request and opcode, sampled only while idle
//   a, b       : rs / rt operands
//   busy       : iterative op in flight (state != IDLE)
//   done       : one-cycle pulse, HI/LO already updated
//   hi, lo     : architectural HI/LO
//   divz_err   : only with MULDIV_DIVZERO_TRAP_EN; pulses with done on divide by zero
import muldiv_pkg::*;

module muldiv_ctrl #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIVZERO_TRAP_EN
    output logic             divz_err,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic               is_div_q;
    logic               neg_q;
    logic               rneg_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
`ifdef MULDIV_DIVZERO_TRAP_EN
    logic               divz_q;
`endif

    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic               trap_hit;
    logic               load;
    logic               step;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    always_comb begin
        sgn_op   = ~op[0];
        a_neg    = sgn_op & a[WIDTH-1];
        b_neg    = sgn_op & b[WIDTH-1];
        b_zero   = (b == '0);
        // Negating 0x80.. yields 0x80.., which is the correct unsigned magnitude.
        mag_a_in = a_neg ? -a : a;
        mag_b_in = b_neg ? -b : b;
`ifdef MULDIV_DIVZERO_TRAP_EN
        trap_hit = ~op[2] & op[1] & b_zero;
`else
        trap_hit = 1'b0;
`endif
        load = (state_q == IDLE) & start & ~op[2] & ~trap_hit;
        step = (state_q == RUN);
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (is_div_q),
        .a_bit  (mag_a_q[WIDTH-1]),
        .op_b   (mag_b_q),
        .acc    (acc)
    );

    // Sign correction applied in FIX. A zero divisor leaves neg_q clear, so the
    // quotient stays all ones, while rneg_q turns the |a| remainder back into a.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        if (is_div_q) begin
            lo_d = neg_q  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            hi_d = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            divz_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            divz_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi_q   <= a;
                            done_q <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo_q   <= a;
                            done_q <= 1'b1;
                        end else if (trap_hit) begin
                            done_q <= 1'b1;
`ifdef MULDIV_DIVZERO_TRAP_EN
                            divz_q <= 1'b1;
`endif
                        end else if (!op[2]) begin
                            state_q  <= RUN;
                            cnt_q    <= '0;
                            mag_a_q  <= mag_a_in;
                            mag_b_q  <= mag_b_in;
                            is_div_q <= op[1];
                            neg_q    <= (a_neg ^ b_neg) & ~b_zero;
                            rneg_q   <= a_neg & op[1];
                        end
                    end
                end
                RUN: begin
                    mag_a_q <= {mag_a_q[WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIVZERO_TRAP_EN
    assign divz_err = divz_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULDIV_DIVZERO_TRAP_EN
    logic        divz_err;
`endif

    int checks = 0;
    int passes = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
`ifdef MULDIV_DIVZERO_TRAP_EN
        .divz_err (divz_err),
`endif
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Called #1 after an edge (cycle T); returns #1 into T+1.
    task automatic start_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles since T until done, noting whether busy was high throughout.
    task automatic wait_done(input int cyc0, output int cyc, output bit busy_ok);
        cyc     = cyc0;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0)
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        else passes++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult;
        int cyc; bit bok;
        start_op(3'b000, 32'hFFFFFFFD, 32'd7);
        wait_done(1, cyc, bok);
        checks++;
        if (cyc !== 34 || !bok) $display("FAIL mult_latency: cyc=%0d busy_ok=%b, want 34/1", cyc, bok);
        else passes++;
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) $display("FAIL mult_result: %h_%h, want ffffffff_ffffffeb", hi, lo);
        else passes++;
    endtask

    task automatic test_back_to_back;
        int cyc; bit bok;
        start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1, cyc, bok);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) $display("FAIL multu_result: %h_%h, want fffffffe_00000001", hi, lo);
        else passes++;
        // Restart in the done cycle.
        start_op(3'b000, 32'h80000000, 32'd2);
        wait_done(1, cyc, bok);
        checks++;
        if (cyc !== 34 || !bok) $display("FAIL b2b_latency: cyc=%0d busy_ok=%b, want 34/1", cyc, bok);
        else passes++;
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_00000000) $display("FAIL b2b_result: %h_%h, want ffffffff_00000000", hi, lo);
        else passes++;
    endtask

    task automatic test_div;
        int cyc; bit bok;
        start_op(3'b010, 32'hFFFFFFF9, 32'd2);
        wait_done(1, cyc, bok);
        checks++;
        if (cyc !== 34 || !bok) $display("FAIL div_latency: cyc=%0d busy_ok=%b, want 34/1", cyc, bok);
        else passes++;
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) $display("FAIL div_neg: hi=%h lo=%h, want ffffffff/fffffffd", hi, lo);
        else passes++;
        start_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1, cyc, bok);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h80000000) $display("FAIL div_overflow: hi=%h lo=%h, want 0/80000000", hi, lo);
        else passes++;
        start_op(3'b011, 32'hFFFFFFFF, 32'h10);
        wait_done(1, cyc, bok);
        checks++;
        if (hi !== 32'hF || lo !== 32'h0FFFFFFF) $display("FAIL divu: hi=%h lo=%h, want f/0fffffff", hi, lo);
        else passes++;
    endtask

    task automatic test_divzero;
        int cyc; bit bok;
`ifdef MULDIV_DIVZERO_TRAP_EN
        logic [31:0] hi0, lo0;
        hi0 = hi;
        lo0 = lo;
        start_op(3'b011, 32'd100, 32'd0);
        checks++;
        if (done !== 1'b1 || divz_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL divz_trap: done=%b divz_err=%b busy=%b, want 1/1/0", done, divz_err, busy);
        else passes++;
        checks++;
        if (hi !== hi0 || lo !== lo0) $display("FAIL divz_hold: hi=%h lo=%h, want %h/%h", hi, lo, hi0, lo0);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || divz_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL divz_pulse: done=%b divz_err=%b busy=%b, want 0/0/0", done, divz_err, busy);
        else passes++;
`else
        start_op(3'b011, 32'd100, 32'd0);
        wait_done(1, cyc, bok);
        checks++;
        if (cyc !== 34 || !bok) $display("FAIL divz_latency: cyc=%0d busy_ok=%b, want 34/1", cyc, bok);
        else passes++;
        checks++;
        if (hi !== 32'd100 || lo !== 32'hFFFFFFFF) $display("FAIL divz_result: hi=%h lo=%h, want 64/ffffffff", hi, lo);
        else passes++;
        start_op(3'b010, 32'hFFFFFFF0, 32'd0);
        wait_done(1, cyc, bok);
        checks++;
        if (hi !== 32'hFFFFFFF0 || lo !== 32'hFFFFFFFF) $display("FAIL divz_signed: hi=%h lo=%h, want fffffff0/ffffffff", hi, lo);
        else passes++;
`endif
    endtask

    task automatic test_mtlo;
        logic [31:0] hi0;
        hi0 = hi;
        start_op(3'b101, 32'h1234, 32'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || lo !== 32'h1234 || hi !== hi0)
            $display("FAIL mtlo: done=%b busy=%b lo=%h hi=%h, want 1/0/00001234/%h", done, busy, lo, hi, hi0);
        else passes++;
        @(posedge clk);
        #1;
        // Unused opcode: no done, no state change.
        start_op(3'b110, 32'hAAAA5555, 32'd1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'h1234 || hi !== hi0)
            $display("FAIL unused_op: done=%b busy=%b lo=%h hi=%h, want 0/0/00001234/%h", done, busy, lo, hi, hi0);
        else passes++;
    endtask

    task automatic test_mthi_busy;
        int cyc; bit bok;
        start_op(3'b001, 32'h00010000, 32'h00030000);
        repeat (4) @(posedge clk);
        #1;
        start_op(3'b100, 32'hDEADBEEF, 32'd0);
        wait_done(6, cyc, bok);
        checks++;
        if (cyc !== 34 || !bok) $display("FAIL mthi_busy_latency: cyc=%0d busy_ok=%b, want 34/1", cyc, bok);
        else passes++;
        checks++;
        if (hi !== 32'd3 || lo !== 32'd0) $display("FAIL mthi_busy_result: hi=%h lo=%h, want 3/0", hi, lo);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int cyc; bit bok;
        start_op(3'b000, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0)
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        start_op(3'b001, 32'd6, 32'd7);
        wait_done(1, cyc, bok);
        checks++;
        if (cyc !== 34 || !bok || hi !== 32'd0 || lo !== 32'd42)
            $display("FAIL reset_recover: cyc=%0d busy_ok=%b hi=%h lo=%h, want 34/1/0/2a", cyc, bok, hi, lo);
        else passes++;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_back_to_back;
        test_div;
        test_divzero;
        test_mtlo;
        test_mthi_busy;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
